// File: rtl/cv32e40px_pkg.sv
// Shared types for the cv.elw event controller: FSM states, config register map
// and the bundled config request.
package cv32e40px_pkg;

  typedef enum logic [2:0] {
    ELW_IDLE  = 3'd0,
    ELW_WAIT  = 3'd1,
    ELW_SLEEP = 3'd2,
    ELW_WAKE  = 3'd3,
    ELW_RESP  = 3'd4
  } elw_state_e;

  localparam logic [1:0] ELW_REG_MASK    = 2'd0;
  localparam logic [1:0] ELW_REG_PENDING = 2'd1;
  localparam logic [1:0] ELW_REG_BUF_CLR = 2'd2;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } elw_cfg_req_t;

endpackage

// File: rtl/cv32e40px_ff_one.sv
// Lowest-set-bit finder: index of the least significant 1 in in_i.
module cv32e40px_ff_one #(
  parameter int LEN   = 8,
  parameter int IDX_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic [LEN-1:0]   in_i,
  output logic [IDX_W-1:0] first_one_o,
  output logic             no_ones_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = IDX_W'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40px_elw_event_ctrl.sv
// cv.elw event unit: pending/mask event registers, sleep/wake FSM and the
// core clock enable.
module cv32e40px_elw_event_ctrl
  import cv32e40px_pkg::*;
#(
  parameter int N_EVENTS = 8
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [N_EVENTS-1:0] event_i,
  input  logic                cfg_req_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [31:0]         cfg_wdata_i,
  output logic [31:0]         cfg_rdata_o,
  input  logic                elw_req_i,
  output logic                elw_gnt_o,
  output logic                elw_rvalid_o,
  output logic [31:0]         elw_rdata_o,
  input  logic                core_sleep_i,
  input  logic                debug_req_i,
  output logic                pulp_clock_en_o
);

  localparam int ID_W = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1;

  elw_cfg_req_t        cfg;
  elw_state_e          state_q, state_d;
  logic [N_EVENTS-1:0] mask_q, mask_d, pend_q, pend_d;
  logic [N_EVENTS-1:0] clr_wr, clr_resp, pend_seen, hit;
  logic [ID_W-1:0]     hit_id, id_q;
  logic                fire, no_hit, clken_q;
  logic                unused_wdata;

  assign cfg = '{req: cfg_req_i, we: cfg_we_i, addr: cfg_addr_i, wdata: cfg_wdata_i};
  assign unused_wdata = ^cfg.wdata;

  always_comb begin
    mask_d = mask_q;
    clr_wr = '0;
    if (cfg.req && cfg.we) begin
      unique case (cfg.addr)
        ELW_REG_MASK:                    mask_d = cfg.wdata[N_EVENTS-1:0];
        ELW_REG_PENDING, ELW_REG_BUF_CLR: clr_wr = cfg.wdata[N_EVENTS-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    clr_resp = '0;
    if (state_q == ELW_RESP) clr_resp[id_q] = 1'b1;
  end

  // Fire looks at this cycle's writes and events so the FSM reacts without
  // waiting a cycle for the registers; new events always beat clears.
  assign pend_seen = (pend_q & ~clr_wr) | event_i;
  assign pend_d    = (pend_q & ~clr_wr & ~clr_resp) | event_i;
  assign hit       = pend_seen & mask_d;
  assign fire      = ~no_hit;

  cv32e40px_ff_one #(
    .LEN   (N_EVENTS),
    .IDX_W (ID_W)
  ) u_ff_one (
    .in_i        (hit),
    .first_one_o (hit_id),
    .no_ones_o   (no_hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mask_q <= '0;
      pend_q <= '0;
      id_q   <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      if (state_d == ELW_RESP) id_q <= hit_id;
    end
  end

  // State register; the clock enable is registered from the next state so it
  // changes only on the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q <= ELW_IDLE;
      clken_q <= 1'b1;
    end else begin
      state_q <= state_d;
      clken_q <= (state_d != ELW_SLEEP);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ELW_IDLE:  if (elw_req_i) state_d = ELW_WAIT;
      ELW_WAIT: begin
        if (fire)                              state_d = ELW_RESP;
        else if (core_sleep_i && !debug_req_i) state_d = ELW_SLEEP;
      end
      ELW_SLEEP: if (fire || debug_req_i) state_d = ELW_WAKE;
      ELW_WAKE:  state_d = fire ? ELW_RESP : ELW_WAIT;
      ELW_RESP:  state_d = ELW_IDLE;
      default:   state_d = ELW_IDLE;
    endcase
  end

  always_comb begin
    elw_gnt_o           = (state_q == ELW_IDLE) && elw_req_i;
    elw_rvalid_o        = (state_q == ELW_RESP) && clken_q;
    elw_rdata_o         = '0;
    if (elw_rvalid_o) elw_rdata_o[ID_W-1:0] = id_q;
    pulp_clock_en_o     = clken_q;
  end

  always_comb begin
    cfg_rdata_o = '0;
    if (cfg.req) begin
      unique case (cfg.addr)
        ELW_REG_MASK:    cfg_rdata_o[N_EVENTS-1:0] = mask_q;
        ELW_REG_PENDING: cfg_rdata_o[N_EVENTS-1:0] = pend_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cv32e40px_elw_event_ctrl.sv
// Bench for the cv.elw event controller: directed vector table, a reset-in-sleep
// sequence, then random traffic against a behavioural model.
module tb_cv32e40px_elw_event_ctrl;

  localparam int N = 8;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic [N-1:0]  event_i;
  logic          cfg_req_i, cfg_we_i;
  logic [1:0]    cfg_addr_i;
  logic [31:0]   cfg_wdata_i, cfg_rdata_o;
  logic          elw_req_i, elw_gnt_o, elw_rvalid_o;
  logic [31:0]   elw_rdata_o;
  logic          core_sleep_i, debug_req_i, pulp_clock_en_o;

  always #5 clk_i = ~clk_i;

  cv32e40px_elw_event_ctrl #(.N_EVENTS(N)) dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .event_i         (event_i),
    .cfg_req_i       (cfg_req_i),
    .cfg_we_i        (cfg_we_i),
    .cfg_addr_i      (cfg_addr_i),
    .cfg_wdata_i     (cfg_wdata_i),
    .cfg_rdata_o     (cfg_rdata_o),
    .elw_req_i       (elw_req_i),
    .elw_gnt_o       (elw_gnt_o),
    .elw_rvalid_o    (elw_rvalid_o),
    .elw_rdata_o     (elw_rdata_o),
    .core_sleep_i    (core_sleep_i),
    .debug_req_i     (debug_req_i),
    .pulp_clock_en_o (pulp_clock_en_o)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  ev;
    logic        creq, cwe;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ereq, slp, dbg;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        ck;
    logic [31:0] crd;
  } vec_t;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];

  // Model: what the elw request is currently doing, in plain words.
  localparam int PH_IDLE = 0, PH_WAITING = 1, PH_ASLEEP = 2, PH_WOKEN = 3, PH_ANSWER = 4;
  int         ph;
  int         m_id;
  logic [7:0] m_mask, m_pend;

  function automatic vec_t v(input logic r, input logic [7:0] ev, input logic creq, cwe,
                             input logic [1:0] a, input logic [31:0] wd,
                             input logic ereq, slp, dbg, gnt, rv, input logic [31:0] rd,
                             input logic ck, input logic [31:0] crd);
    vec_t t;
    t.rst = r; t.ev = ev; t.creq = creq; t.cwe = cwe; t.addr = a; t.wdata = wd;
    t.ereq = ereq; t.slp = slp; t.dbg = dbg;
    t.gnt = gnt; t.rv = rv; t.rd = rd; t.ck = ck; t.crd = crd;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input vec_t s, input bit tbl_chk, input bit mdl_chk);
    logic [7:0]  clr, nmask, seen, hit;
    logic [31:0] e_crd;
    int          low;
    bit          fire;
    @(negedge clk_i);
    rst_n = s.rst; event_i = s.ev; cfg_req_i = s.creq; cfg_we_i = s.cwe;
    cfg_addr_i = s.addr; cfg_wdata_i = s.wdata; elw_req_i = s.ereq;
    core_sleep_i = s.slp; debug_req_i = s.dbg;
    #1;
    if (mdl_chk) begin
      e_crd = 0;
      if (s.creq && s.addr == 0) e_crd = {24'd0, m_mask};
      if (s.creq && s.addr == 1) e_crd = {24'd0, m_pend};
      cmp("model_gnt",   {31'd0, elw_gnt_o},       {31'd0, (ph == PH_IDLE) && s.ereq});
      cmp("model_rvld",  {31'd0, elw_rvalid_o},    {31'd0, ph == PH_ANSWER});
      cmp("model_rdata", elw_rdata_o,              (ph == PH_ANSWER) ? 32'(m_id) : 32'd0);
      cmp("model_clken", {31'd0, pulp_clock_en_o}, {31'd0, ph != PH_ASLEEP});
      cmp("model_crd",   cfg_rdata_o,              e_crd);
    end
    if (tbl_chk) begin
      cmp("vec_gnt",   {31'd0, elw_gnt_o},       {31'd0, s.gnt});
      cmp("vec_rvld",  {31'd0, elw_rvalid_o},    {31'd0, s.rv});
      cmp("vec_rdata", elw_rdata_o,              s.rd);
      cmp("vec_clken", {31'd0, pulp_clock_en_o}, {31'd0, s.ck});
      cmp("vec_crd",   cfg_rdata_o,              s.crd);
    end
    // advance the model to what the next edge should produce
    if (!s.rst) begin
      ph = PH_IDLE; m_mask = 0; m_pend = 0; m_id = 0;
    end else begin
      nmask = (s.creq && s.cwe && s.addr == 0) ? s.wdata[7:0] : m_mask;
      clr   = (s.creq && s.cwe && (s.addr == 1 || s.addr == 2)) ? s.wdata[7:0] : 8'd0;
      seen  = (m_pend & ~clr) | s.ev;
      hit   = seen & nmask;
      fire  = (hit != 0);
      low   = 0;
      for (int i = N - 1; i >= 0; i--) if (hit[i]) low = i;
      if (ph == PH_ANSWER) seen[m_id] = 1'b0;
      m_pend = seen | s.ev;
      m_mask = nmask;
      case (ph)
        PH_IDLE:    if (s.ereq) ph = PH_WAITING;
        PH_WAITING: if (fire) begin ph = PH_ANSWER; m_id = low; end
                    else if (s.slp && !s.dbg) ph = PH_ASLEEP;
        PH_ASLEEP:  if (fire || s.dbg) ph = PH_WOKEN;
        PH_WOKEN:   if (fire) begin ph = PH_ANSWER; m_id = low; end
                    else ph = PH_WAITING;
        default:    ph = PH_IDLE;
      endcase
    end
  endtask

  initial begin
    vec_t r;
    ph = PH_IDLE; m_id = 0; m_mask = 0; m_pend = 0;
    r = v(0, 0, 0,0,0,0, 0,0,0, 0,0,0,1,0);
    step(r, 0, 0);
    step(r, 0, 1);

    //        rst ev     rq we a wdata        er sl db  gnt rv rd ck crd
    tbl.push_back(v(1, 8'h00, 1,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'h04,       0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,0,32'h0,        1,0,0,  1,0,0,1,32'h04));
    tbl.push_back(v(1, 8'h04, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,1,2,1,32'h04));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'h01,       0,0,0,  0,0,0,1,32'h04));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        1,1,0,  1,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,0,  0,0,0,0,32'h0));
    tbl.push_back(v(1, 8'h01, 0,0,0,32'h0,        0,1,0,  0,0,0,0,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,0,0,  0,1,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'hFF,       0,0,0,  0,0,0,1,32'h01));
    tbl.push_back(v(1, 8'h28, 0,0,0,32'h0,        1,0,0,  1,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,1,3,1,32'h28));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h20));
    tbl.push_back(v(1, 8'h00, 1,1,1,32'hFF,       0,0,0,  0,0,0,1,32'h20));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        1,1,0,  1,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,1,  0,0,0,0,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'h0,        0,0,0,  0,0,0,1,32'hFF));
    tbl.push_back(v(1, 8'h10, 0,0,0,32'h0,        0,1,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,1,0,  0,0,0,0,32'h10));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'h10,       0,1,0,  0,0,0,0,32'h0));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        0,1,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,1,4,1,32'h10));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h02, 0,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h02, 1,1,1,32'h02,       0,0,0,  0,0,0,1,32'h02));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h02));
    tbl.push_back(v(1, 8'h00, 1,1,2,32'h02,       0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h00, 1,1,0,32'hFFFFFF30, 0,0,0,  0,0,0,1,32'h10));
    tbl.push_back(v(1, 8'h00, 1,0,0,32'h0,        0,0,0,  0,0,0,1,32'h30));
    tbl.push_back(v(1, 8'h00, 0,0,0,32'h0,        1,0,0,  1,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h10, 0,0,0,32'h0,        0,0,0,  0,0,0,1,32'h0));
    tbl.push_back(v(1, 8'h10, 1,0,1,32'h0,        0,0,0,  0,1,4,1,32'h10));
    tbl.push_back(v(1, 8'h00, 1,0,1,32'h0,        0,0,0,  0,0,0,1,32'h10));
    foreach (tbl[i]) step(tbl[i], 1, 1);

    // reset while asleep: request is dropped, clock comes back, registers clear
    step(v(1, 8'h00, 1,1,0,32'h0, 0,0,0, 0,0,0,1,32'h30), 1, 1);
    step(v(1, 8'h00, 0,0,0,32'h0, 1,1,0, 1,0,0,1,32'h0),  1, 1);
    step(v(1, 8'h00, 0,0,0,32'h0, 0,1,0, 0,0,0,1,32'h0),  1, 1);
    step(v(0, 8'h00, 0,0,0,32'h0, 0,1,0, 0,0,0,0,32'h0),  1, 1);
    step(v(1, 8'h00, 1,0,0,32'h0, 0,1,0, 0,0,0,1,32'h0),  1, 1);
    step(v(1, 8'h00, 1,0,1,32'h0, 0,1,0, 0,0,0,1,32'h0),  1, 1);
    step(v(1, 8'h01, 0,0,0,32'h0, 0,1,0, 0,0,0,1,32'h0),  1, 1);
    step(v(1, 8'h00, 0,0,0,32'h0, 0,0,0, 0,0,0,1,32'h0),  1, 1);

    for (int k = 0; k < 4000; k++) begin
      r = v(($urandom_range(0, 199) != 0), 8'h00, ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
            0, 0, 0, 0, 0);
      if ($urandom_range(0, 5) == 0) r.ev = 8'($urandom) & 8'($urandom);
      step(r, 0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
